// File: rtl/block_map.sv
// block_map: 33x27 arena tile map with init sweep, single-shot clears and registered lookups.
// Define BLOCK_MAP_RANDOM_EN for LFSR-driven breakable placement instead of the even/even grid.
module block_map (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x_a,
    input  logic [9:0] y_a,
    input  logic [9:0] block_w_addr,
    input  logic       block_we,
    input  logic [5:0] qx,
    input  logic [5:0] qy,
    output logic       q_blocked,
    output logic       block_on,
    output logic       pillar_on,
    output logic       init_done,
    output logic [9:0] blocks_left,
    output logic       block_cleared
);
    localparam logic [9:0] CELLS = 10'd891;
    typedef enum logic {INIT, RUN} state_t;
    state_t state, state_next;
    logic [1:0] mem [0:890];
    logic [9:0] init_addr, pix_addr, q_addr;
    logic [5:0] ix, iy, px, py;
    logic [1:0] init_cell, pix_cell, q_cell, w_cell;
    logic       pix_ok, q_ok, clr, breakable, last, unused_ok;
    assign unused_ok = ^{x_a[3:0], y_a[3:0]};
    assign px = x_a[9:4];
    assign py = y_a[9:4];
    assign pix_ok = px <= 6'd32 && py <= 6'd26;
    assign q_ok = qx <= 6'd32 && qy <= 6'd26;
    assign pix_addr = 10'(px) + 10'(py) * 10'd33;
    assign q_addr = 10'(qx) + 10'(qy) * 10'd33;
    assign pix_cell = pix_ok ? mem[pix_addr] : 2'd0;
    assign q_cell = q_ok ? mem[q_addr] : 2'd0;
    assign w_cell = block_w_addr < CELLS ? mem[block_w_addr] : 2'd0;
    assign clr = state == RUN && block_we && w_cell == 2'd1;
    assign last = init_addr == CELLS - 10'd1;
    assign init_done = state == RUN;
`ifdef BLOCK_MAP_RANDOM_EN
    logic [9:0] lfsr;
    always_ff @(posedge clk) begin
        if (!reset)
            lfsr <= 10'h2A5;
        else if (state == INIT)
            lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
    end
    assign breakable = lfsr[0];
`else
    assign breakable = ~ix[0] & ~iy[0];
`endif
    // pillars win, then the spawn corner stays clear, then the placement rule
    assign init_cell = (ix[0] & iy[0]) ? 2'd2 :
                       (7'(ix) + 7'(iy) <= 7'd2) ? 2'd0 :
                       breakable ? 2'd1 : 2'd0;
    always_comb begin
        state_next = (state == INIT && last) ? RUN : state;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= INIT;
            init_addr     <= '0;
            ix            <= '0;
            iy            <= '0;
            blocks_left   <= '0;
            block_cleared <= 1'b0;
            block_on      <= 1'b0;
            pillar_on     <= 1'b0;
            q_blocked     <= 1'b1;
        end else begin
            state         <= state_next;
            block_cleared <= clr;
            block_on      <= state == RUN && pix_cell == 2'd1;
            pillar_on     <= state == RUN && pix_cell == 2'd2;
            q_blocked     <= state != RUN || !q_ok || q_cell != 2'd0;
            if (state == INIT) begin
                init_addr <= init_addr + 10'd1;
                ix        <= ix == 6'd32 ? 6'd0 : ix + 6'd1;
                iy        <= ix == 6'd32 ? iy + 6'd1 : iy;
                if (init_cell == 2'd1)
                    blocks_left <= blocks_left + 10'd1;
            end else if (clr && blocks_left != 10'd0) begin
                blocks_left <= blocks_left - 10'd1;
            end
        end
    end
    // map storage needs no reset: INIT rewrites every cell
    always_ff @(posedge clk) begin
        if (reset && state == INIT)
            mem[init_addr] <= init_cell;
        else if (reset && clr)
            mem[block_w_addr] <= 2'd0;
    end
endmodule
